// File: rtl/reg_read_stage_if.sv
// Bundle of issue-side, rename, writeback, flush and execute-side signals
// around the register-read stage.
interface reg_read_stage_if #(
    parameter int PREG_W = 6,
    parameter int DATA_W = 32,
    parameter int UOP_W  = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [PREG_W-1:0] in_rs_preg;
    logic              in_rs_used;
    logic [PREG_W-1:0] in_rt_preg;
    logic              in_rt_used;
    logic [PREG_W-1:0] in_rd_preg;
    logic [UOP_W-1:0]  in_uop;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              wb_valid;
    logic [PREG_W-1:0] wb_preg;
    logic [DATA_W-1:0] wb_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [PREG_W-1:0] out_rd_preg;
    logic [UOP_W-1:0]  out_uop;

    modport slave (
        input  in_valid, in_rs_preg, in_rs_used, in_rt_preg, in_rt_used,
               in_rd_preg, in_uop, alloc_valid, alloc_preg, wb_valid,
               wb_preg, wb_data, flush, out_ready,
        output in_ready, out_valid, out_rs_data, out_rt_data, out_rd_preg,
               out_uop
    );

    modport master (
        output in_valid, in_rs_preg, in_rs_used, in_rt_preg, in_rt_used,
               in_rd_preg, in_uop, alloc_valid, alloc_preg, wb_valid,
               wb_preg, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_rs_data, out_rt_data, out_rd_preg,
               out_uop
    );
endinterface

// File: rtl/reg_read_stage.sv
// Register-read stage: hold slot H waits for operands, output slot O feeds execute.
// Optional stall counter port perf_stall_cnt enabled by defining RR_STALL_CNT_EN.
module reg_read_stage #(
    parameter int PREG_W = 6,
    parameter int DATA_W = 32,
    parameter int UOP_W  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    reg_read_stage_if.slave  bus
`ifdef RR_STALL_CNT_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);
    localparam int NREG = 1 << PREG_W;

    logic [DATA_W-1:0] rf_rd  [NREG];
    logic              rdy_rd [NREG];

    // Entry 0 is a constant zero that is always ready.
    for (genvar g = 0; g < NREG; g++) begin : g_rf
        if (g == 0) begin : g_zero
            assign rf_rd[g]  = '0;
            assign rdy_rd[g] = 1'b1;
        end else begin : g_ent
            logic [DATA_W-1:0] data_q;
            logic              rdy_q;
            logic              we;
            logic              al;
            assign we = bus.wb_valid && (bus.wb_preg == PREG_W'(g));
            assign al = bus.alloc_valid && (bus.alloc_preg == PREG_W'(g));
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                    rdy_q  <= 1'b1;
                end else begin
                    if (we) data_q <= bus.wb_data;
                    if (al)      rdy_q <= 1'b0;
                    else if (we) rdy_q <= 1'b1;
                end
            end
            assign rf_rd[g]  = data_q;
            assign rdy_rd[g] = rdy_q;
        end
    end

    logic              h_valid_q, h_valid_d;
    logic [PREG_W-1:0] h_rs_q, h_rs_d, h_rt_q, h_rt_d, h_rd_q, h_rd_d;
    logic              h_rs_used_q, h_rs_used_d, h_rt_used_q, h_rt_used_d;
    logic [UOP_W-1:0]  h_uop_q, h_uop_d;

    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_rs_q, o_rs_d, o_rt_q, o_rt_d;
    logic [PREG_W-1:0] o_rd_q, o_rd_d;
    logic [UOP_W-1:0]  o_uop_q, o_uop_d;

    logic              rs_hit, rt_hit, rs_ok, rt_ok, srcs_ok;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              xfer, in_ready, accept;

    always_comb begin
        // Same-cycle writeback is forwarded so a waiting entry can leave immediately.
        rs_hit  = bus.wb_valid && (bus.wb_preg == h_rs_q) && (h_rs_q != '0);
        rt_hit  = bus.wb_valid && (bus.wb_preg == h_rt_q) && (h_rt_q != '0);
        rs_ok   = !h_rs_used_q || rdy_rd[h_rs_q] || rs_hit;
        rt_ok   = !h_rt_used_q || rdy_rd[h_rt_q] || rt_hit;
        srcs_ok = rs_ok && rt_ok;
        rs_val  = !h_rs_used_q ? '0 : (rs_hit ? bus.wb_data : rf_rd[h_rs_q]);
        rt_val  = !h_rt_used_q ? '0 : (rt_hit ? bus.wb_data : rf_rd[h_rt_q]);
        xfer     = h_valid_q && srcs_ok && (!o_valid_q || bus.out_ready);
        in_ready = !bus.flush && (!h_valid_q || xfer);
        accept   = bus.in_valid && in_ready;
    end

    always_comb begin
        h_valid_d   = h_valid_q;
        h_rs_d      = h_rs_q;
        h_rs_used_d = h_rs_used_q;
        h_rt_d      = h_rt_q;
        h_rt_used_d = h_rt_used_q;
        h_rd_d      = h_rd_q;
        h_uop_d     = h_uop_q;
        if (bus.flush) begin
            h_valid_d = 1'b0;
        end else if (accept) begin
            h_valid_d   = 1'b1;
            h_rs_d      = bus.in_rs_preg;
            h_rs_used_d = bus.in_rs_used;
            h_rt_d      = bus.in_rt_preg;
            h_rt_used_d = bus.in_rt_used;
            h_rd_d      = bus.in_rd_preg;
            h_uop_d     = bus.in_uop;
        end else if (xfer) begin
            h_valid_d = 1'b0;
        end

        o_valid_d = o_valid_q;
        o_rs_d    = o_rs_q;
        o_rt_d    = o_rt_q;
        o_rd_d    = o_rd_q;
        o_uop_d   = o_uop_q;
        if (bus.flush) begin
            o_valid_d = 1'b0;
        end else if (xfer) begin
            o_valid_d = 1'b1;
            o_rs_d    = rs_val;
            o_rt_d    = rt_val;
            o_rd_d    = h_rd_q;
            o_uop_d   = h_uop_q;
        end else if (bus.out_ready) begin
            o_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_valid_q   <= 1'b0;
            h_rs_q      <= '0;
            h_rs_used_q <= 1'b0;
            h_rt_q      <= '0;
            h_rt_used_q <= 1'b0;
            h_rd_q      <= '0;
            h_uop_q     <= '0;
            o_valid_q   <= 1'b0;
            o_rs_q      <= '0;
            o_rt_q      <= '0;
            o_rd_q      <= '0;
            o_uop_q     <= '0;
        end else begin
            h_valid_q   <= h_valid_d;
            h_rs_q      <= h_rs_d;
            h_rs_used_q <= h_rs_used_d;
            h_rt_q      <= h_rt_d;
            h_rt_used_q <= h_rt_used_d;
            h_rd_q      <= h_rd_d;
            h_uop_q     <= h_uop_d;
            o_valid_q   <= o_valid_d;
            o_rs_q      <= o_rs_d;
            o_rt_q      <= o_rt_d;
            o_rd_q      <= o_rd_d;
            o_uop_q     <= o_uop_d;
        end
    end

`ifdef RR_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_q <= '0;
        else if (h_valid_q && !srcs_ok && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end
    assign perf_stall_cnt = stall_cnt_q;
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = o_valid_q;
    assign bus.out_rs_data = o_rs_q;
    assign bus.out_rt_data = o_rt_q;
    assign bus.out_rd_preg = o_rd_q;
    assign bus.out_uop     = o_uop_q;
endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: operand vector table plus stall, backpressure,
// flush and reset sequences.
module tb_reg_read_stage;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    reg_read_stage_if #(.PREG_W(6), .DATA_W(32), .UOP_W(64)) rr ();

`ifdef RR_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    reg_read_stage #(.PREG_W(6), .DATA_W(32), .UOP_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rr)
`ifdef RR_STALL_CNT_EN
        ,
        .perf_stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  rs;
        logic        rs_used;
        logic [5:0]  rt;
        logic        rt_used;
        logic [5:0]  rd;
        logic [63:0] uop;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] rs, input logic rsu, input logic [5:0] rt,
                         input logic rtu, input logic [5:0] rd, input logic [63:0] uop);
        rr.in_valid   = 1'b1;
        rr.in_rs_preg = rs;
        rr.in_rs_used = rsu;
        rr.in_rt_preg = rt;
        rr.in_rt_used = rtu;
        rr.in_rd_preg = rd;
        rr.in_uop     = uop;
    endtask

    function automatic logic [31:0] rfval(input int p);
        return 32'hA000_0000 + 32'(p) * 32'h0101;
    endfunction

    initial begin
        vecs[0] = '{6'd1,  1'b1, 6'd2,  1'b1, 6'd11, 64'h1111_0000_0000_0001, 32'hA000_0101, 32'hA000_0202};
        vecs[1] = '{6'd3,  1'b1, 6'd4,  1'b0, 6'd12, 64'h2222_0000_0000_0002, 32'hA000_0303, 32'h0};
        vecs[2] = '{6'd0,  1'b1, 6'd5,  1'b1, 6'd13, 64'h3333_0000_0000_0003, 32'h0,          32'hA000_0505};
        vecs[3] = '{6'd6,  1'b0, 6'd7,  1'b0, 6'd14, 64'h4444_0000_0000_0004, 32'h0,          32'h0};
        vecs[4] = '{6'd63, 1'b1, 6'd62, 1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 32'hA000_3F3F, 32'hA000_3E3E};
        vecs[5] = '{6'd10, 1'b1, 6'd10, 1'b1, 6'd0,  64'h0,                   32'hA000_0A0A, 32'hA000_0A0A};

        rst_n = 1'b0;
        rr.in_valid = 1'b0; rr.in_rs_preg = '0; rr.in_rs_used = 1'b0;
        rr.in_rt_preg = '0; rr.in_rt_used = 1'b0; rr.in_rd_preg = '0; rr.in_uop = '0;
        rr.alloc_valid = 1'b0; rr.alloc_preg = '0;
        rr.wb_valid = 1'b0; rr.wb_preg = '0; rr.wb_data = '0;
        rr.flush = 1'b0; rr.out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(rr.out_valid), 64'd0);
        chk("rst_out_rs", 64'(rr.out_rs_data), 64'd0);
        chk("rst_out_rd", 64'(rr.out_rd_preg), 64'd0);
        chk("rst_out_uop", rr.out_uop, 64'd0);
        chk("rst_in_ready", 64'(rr.in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Basic latency: rs=3, rt=0 both used, RF cleared by reset.
        offer(6'd3, 1'b1, 6'd0, 1'b1, 6'd9, 64'hABCD);
        #1 chk("basic_in_ready", 64'(rr.in_ready), 64'd1);
        step();
        rr.in_valid = 1'b0;
        chk("basic_no_early_valid", 64'(rr.out_valid), 64'd0);
        step();
        chk("basic_out_valid", 64'(rr.out_valid), 64'd1);
        chk("basic_rs", 64'(rr.out_rs_data), 64'd0);
        chk("basic_rt", 64'(rr.out_rt_data), 64'd0);
        chk("basic_uop", rr.out_uop, 64'hABCD);
        step();
        chk("basic_drain", 64'(rr.out_valid), 64'd0);

        // Wait on an allocated register, woken by forwarded writeback.
        rr.alloc_valid = 1'b1; rr.alloc_preg = 6'd5;
        step();
        rr.alloc_valid = 1'b0;
        offer(6'd5, 1'b1, 6'd0, 1'b0, 6'd20, 64'h5555);
        #1 chk("wait_in_ready_accept", 64'(rr.in_ready), 64'd1);
        step();
        rr.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("wait_in_ready_low", 64'(rr.in_ready), 64'd0);
            chk("wait_no_valid", 64'(rr.out_valid), 64'd0);
            step();
        end
        rr.wb_valid = 1'b1; rr.wb_preg = 6'd5; rr.wb_data = 32'hDEADBEEF;
        #1 chk("wait_wb_in_ready", 64'(rr.in_ready), 64'd1);
        step();
        rr.wb_valid = 1'b0;
        chk("wait_out_valid", 64'(rr.out_valid), 64'd1);
        chk("wait_rs", 64'(rr.out_rs_data), 64'hDEADBEEF);
        chk("wait_rt", 64'(rr.out_rt_data), 64'd0);
`ifdef RR_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd2);
`endif
        step();

        // Alloc beats writeback on the same register in the same cycle.
        rr.alloc_valid = 1'b1; rr.alloc_preg = 6'd7;
        rr.wb_valid = 1'b1; rr.wb_preg = 6'd7; rr.wb_data = 32'h1111;
        step();
        rr.alloc_valid = 1'b0; rr.wb_valid = 1'b0;
        offer(6'd7, 1'b1, 6'd0, 1'b0, 6'd21, 64'h7777);
        step();
        rr.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("allocwin_no_valid", 64'(rr.out_valid), 64'd0);
            step();
        end
        rr.wb_valid = 1'b1; rr.wb_preg = 6'd7; rr.wb_data = 32'h7777_0007;
        step();
        rr.wb_valid = 1'b0;
        chk("allocwin_out_valid", 64'(rr.out_valid), 64'd1);
        chk("allocwin_rs", 64'(rr.out_rs_data), 64'h7777_0007);
        step();

        for (int p = 1; p < 64; p++) begin
            rr.wb_valid = 1'b1; rr.wb_preg = 6'(p); rr.wb_data = rfval(p);
            step();
        end
        rr.wb_valid = 1'b0;
        step();

        for (int v = 0; v < 6; v++) begin
            offer(vecs[v].rs, vecs[v].rs_used, vecs[v].rt, vecs[v].rt_used, vecs[v].rd, vecs[v].uop);
            #1 chk("vec_in_ready", 64'(rr.in_ready), 64'd1);
            step();
            rr.in_valid = 1'b0;
            chk("vec_not_yet", 64'(rr.out_valid), 64'd0);
            step();
            chk("vec_valid", 64'(rr.out_valid), 64'd1);
            chk("vec_rs", 64'(rr.out_rs_data), 64'(vecs[v].exp_rs));
            chk("vec_rt", 64'(rr.out_rt_data), 64'(vecs[v].exp_rt));
            chk("vec_rd", 64'(rr.out_rd_preg), 64'(vecs[v].rd));
            chk("vec_uop", rr.out_uop, vecs[v].uop);
            step();
        end

        // Eight entries back to back.
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                offer(6'(c + 1), 1'b1, 6'(c + 20), 1'b1, 6'(c + 30), 64'hC0DE_0000_0000_0000 | 64'(c));
                #1 chk("b2b_in_ready", 64'(rr.in_ready), 64'd1);
            end else begin
                rr.in_valid = 1'b0;
            end
            step();
            if (c >= 1 && c <= 8) begin
                chk("b2b_valid", 64'(rr.out_valid), 64'd1);
                chk("b2b_uop", rr.out_uop, 64'hC0DE_0000_0000_0000 | 64'(c - 1));
                chk("b2b_rs", 64'(rr.out_rs_data), 64'(rfval(c)));
                chk("b2b_rt", 64'(rr.out_rt_data), 64'(rfval(c + 19)));
            end else if (c == 9) begin
                chk("b2b_end", 64'(rr.out_valid), 64'd0);
            end
        end

        // Backpressure with both slots full.
        rr.out_ready = 1'b0;
        offer(6'd1, 1'b1, 6'd2, 1'b1, 6'd40, 64'hE1);
        #1 chk("bp_in_ready1", 64'(rr.in_ready), 64'd1);
        step();
        offer(6'd3, 1'b1, 6'd4, 1'b1, 6'd41, 64'hE2);
        #1 chk("bp_in_ready2", 64'(rr.in_ready), 64'd1);
        step();
        offer(6'd5, 1'b1, 6'd6, 1'b1, 6'd42, 64'hE3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready_low", 64'(rr.in_ready), 64'd0);
            chk("bp_valid", 64'(rr.out_valid), 64'd1);
            chk("bp_uop_stable", rr.out_uop, 64'hE1);
            chk("bp_rs_stable", 64'(rr.out_rs_data), 64'(rfval(1)));
            step();
        end
        rr.in_valid = 1'b0;
        rr.out_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(rr.in_ready), 64'd1);
        step();
        chk("bp_second_valid", 64'(rr.out_valid), 64'd1);
        chk("bp_second_uop", rr.out_uop, 64'hE2);
        chk("bp_second_rs", 64'(rr.out_rs_data), 64'(rfval(3)));
        step();
        chk("bp_empty", 64'(rr.out_valid), 64'd0);

        // Flush with both slots full and a new entry offered.
        rr.out_ready = 1'b0;
        offer(6'd1, 1'b1, 6'd2, 1'b1, 6'd43, 64'hF1);
        step();
        offer(6'd3, 1'b1, 6'd4, 1'b1, 6'd44, 64'hF2);
        step();
        offer(6'd5, 1'b1, 6'd6, 1'b1, 6'd45, 64'hF3);
        rr.flush = 1'b1;
        rr.out_ready = 1'b1;
        #1 chk("flush_in_ready", 64'(rr.in_ready), 64'd0);
        step();
        rr.flush = 1'b0;
        rr.in_valid = 1'b0;
        #1;
        chk("flush_out_valid", 64'(rr.out_valid), 64'd0);
        chk("flush_h_empty", 64'(rr.in_ready), 64'd1);
        step();
        step();
        chk("flush_dropped", 64'(rr.out_valid), 64'd0);

        // Asynchronous reset in the middle of traffic.
        rr.out_ready = 1'b0;
        offer(6'd1, 1'b1, 6'd2, 1'b1, 6'd46, 64'hD1);
        step();
        offer(6'd3, 1'b1, 6'd4, 1'b1, 6'd47, 64'hD2);
        step();
        rr.in_valid = 1'b0;
        chk("mid_full", 64'(rr.out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rr.out_valid), 64'd0);
        chk("mid_rst_uop", rr.out_uop, 64'd0);
        chk("mid_rst_ready", 64'(rr.in_ready), 64'd1);
        rst_n = 1'b1;
        rr.out_ready = 1'b1;
        step();
        chk("mid_no_leftover", 64'(rr.out_valid), 64'd0);
        offer(6'd10, 1'b1, 6'd0, 1'b0, 6'd48, 64'hD3);
        step();
        rr.in_valid = 1'b0;
        step();
        chk("mid_rf_valid", 64'(rr.out_valid), 64'd1);
        chk("mid_rf_cleared", 64'(rr.out_rs_data), 64'd0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_read_stage.md
REG_READ_STAGE -- requirements
Module: reg_read_stage

Interface
REQ-001 Parameter PREG_W, 6, physical register index width; the register file holds 2**PREG_W entries.
REQ-002 Parameter DATA_W, 32, register data width.
REQ-003 Parameter UOP_W, 64, opaque decoded-op payload width, carried unmodified (includes dest-write flag).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  instruction-queue entry offered.
REQ-007 in_ready  out  1  stage accepts offered entry this cycle.
REQ-008 in_rs_preg  in  PREG_W  physical source rs.
REQ-009 in_rs_used  in  1  rs is a real operand.
REQ-010 in_rt_preg  in  PREG_W  physical source rt.
REQ-011 in_rt_used  in  1  rt is a real operand.
REQ-012 in_rd_preg  in  PREG_W  physical destination.
REQ-013 in_uop  in  UOP_W  decoded payload.
REQ-014 alloc_valid  in  1  rename allocated a destination this cycle.
REQ-015 alloc_preg  in  PREG_W  allocated physical register.
REQ-016 wb_valid  in  1  execute writeback valid.
REQ-017 wb_preg  in  PREG_W  writeback physical register.
REQ-018 wb_data  in  DATA_W  writeback value.
REQ-019 flush  in  1  discard all in-flight entries.
REQ-020 out_valid  out  1  operands ready, entry offered to execute.
REQ-021 out_ready  in  1  execute accepts.
REQ-022 out_rs_data  out  DATA_W  rs value (0 if unused).
REQ-023 out_rt_data  out  DATA_W  rt value (0 if unused).
REQ-024 out_rd_preg  out  PREG_W  destination passthrough.
REQ-025 out_uop  out  UOP_W  payload passthrough.

Function
REQ-026 State: register file RF[2**PREG_W], ready bits RDY[2**PREG_W], hold register H (valid+fields), output register O (valid+operand data+fields).
REQ-027 Preg 0 is hardwired: always ready, reads 0, writes and allocs to it are ignored.
REQ-028 Accept when in_valid & in_ready; fields load into H at that edge; in_ready = ~H.valid | xfer (combinational).
REQ-029 src_ok(p) = RDY[p] | (wb_valid & wb_preg==p); unused sources are always ok.
REQ-030 xfer = H.valid & all src_ok & (~O.valid | out_ready); at xfer edge O loads H, with operand = wb_data on same-cycle wb match else RF[p].
REQ-031 Minimum latency: accept at edge N, out_valid at edge N+1; sustained throughput one entry per cycle when operands ready and out_ready=1.
REQ-032 O fields stable while out_valid & ~out_ready; O.valid clears on out_ready with no xfer.
REQ-033 wb_valid writes RF[wb_preg] and sets RDY[wb_preg]; alloc_valid clears RDY[alloc_preg]; same preg same cycle -> alloc wins (RDY=0, RF still written).
REQ-034 flush clears H.valid and O.valid at next edge, overriding accept and xfer; in_ready=0 during flush; RF/RDY unaffected.

Reset
REQ-035 On rst_n low, immediately: H.valid=0, O.valid=0, out_valid=0, all out data/fields 0, RDY all 1, RF all 0.
REQ-036 Reset mid-operation discards H and O contents with no output handshake.

Configuration
REQ-037 With RR_STALL_CNT_EN defined: output perf_stall_cnt [31:0], reset 0, incrementing (saturating at 0xFFFFFFFF) each cycle H.valid & ~all src_ok; cleared by reset only.
REQ-038 Without RR_STALL_CNT_EN: port and counter absent; all other behaviour identical.

Verification
REQ-039 Reset, offer rs=3,rt=0 used, out_ready=1 -> out_valid one cycle after accept, out_rs_data=0, out_rt_data=0.
REQ-040 alloc preg 5; offer rs=5; wb preg 5 data 0xDEADBEEF three cycles later -> out_valid the edge of the wb cycle, out_rs_data=0xDEADBEEF, in_ready=0 while waiting.
REQ-041 Back-to-back 8 entries, operands ready, out_ready=1 -> 8 consecutive out_valid cycles, order and payloads preserved.
REQ-042 out_ready=0 for 4 cycles with O and H full -> in_ready=0, out fields constant; release -> both drain in order.
REQ-043 flush with H and O valid plus in_valid -> next cycle out_valid=0, H empty, offered entry dropped.
REQ-044 alloc and wb to preg 7 same cycle, then offer rs=7 -> no out_valid until later wb to 7.
